// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, bit-period computation, word size.
// UART_TX_PARITY_EN adds the PARITY state to the tx encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_TX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    // Clocks per bit; integer division, so the real baud is rounded up slightly.
    function automatic int uart_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_send_if.sv
// Transmit request / status bundle between the on-chip producer and uart_send.
interface uart_send_if;
    import uart_pkg::*;

    logic                 send_en;
    logic [DATA_BITS-1:0] send_data;
    logic                 uart_txd;
    logic                 uart_busy;
    logic                 uart_done;

    modport master (
        output send_en,
        output send_data,
        input  uart_txd,
        input  uart_busy,
        input  uart_done
    );

    modport slave (
        input  send_en,
        input  send_data,
        output uart_txd,
        output uart_busy,
        output uart_done
    );
endinterface

// File: rtl/uart_bps_tick.sv
// Bit-period timer: counts 0..BPS_CNT-1 while enabled, ticks on the last count,
// and holds at zero while disabled so every bit period starts aligned.
module uart_bps_tick #(
    parameter int BPS_CNT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);

    generate
        if (BPS_CNT < 2 || BPS_CNT > 65535) begin : g_bad_bps
            $fatal(1, "uart_bps_tick: BPS_CNT=%0d outside 2..65535", BPS_CNT);
        end
    endgenerate

    logic [15:0] clk_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt_reg <= 16'd0;
        end else if (!en || clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= 16'd0;
        end else begin
            clk_cnt_reg <= clk_cnt_reg + 16'd1;
        end
    end

    assign tick = en && (clk_cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_send.sv
// UART transmitter: one byte per request, 8N1 frames (8E1 when UART_TX_PARITY_EN
// is defined), with registered txd/busy/done outputs.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst,
    uart_send_if.slave tx
);
    localparam int BPS_CNT = uart_bps_cnt(CLK_FREQ, UART_BPS);

    tx_state_t            state_reg, state_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 txd_reg, txd_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 bit_tick;

`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    uart_bps_tick #(.BPS_CNT(BPS_CNT)) u_bps_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg != TX_IDLE),
        .tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= TX_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // txd_next is the level of the bit that starts on the coming edge, so the
    // pin comes straight from a flop and never glitches.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        txd_next     = txd_reg;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            TX_IDLE: begin
                txd_next = 1'b1;
                if (tx.send_en) begin
                    state_next   = TX_START;
                    bit_cnt_next = 4'd0;
                    shift_next   = tx.send_data;
                    txd_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^tx.send_data;
`endif
                end
            end
            TX_START: begin
                if (bit_tick) begin
                    state_next   = TX_DATA;
                    bit_cnt_next = 4'd0;
                    txd_next     = shift_reg[0];
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                        bit_cnt_next = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_next   = TX_PARITY;
                        txd_next     = parity_reg;
`else
                        state_next   = TX_STOP;
                        txd_next     = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        shift_next   = shift_reg >> 1;
                        txd_next     = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_tick) begin
                    state_next = TX_STOP;
                    txd_next   = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                txd_next = 1'b1;
                if (bit_tick) begin
                    state_next = TX_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = TX_IDLE;
                txd_next   = 1'b1;
            end
        endcase
        busy_next = (state_next != TX_IDLE);
    end

    assign tx.uart_txd  = txd_reg;
    assign tx.uart_busy = busy_reg;
    assign tx.uart_done = done_reg;

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send at BPS_CNT=10; expectations follow UART_TX_PARITY_EN.
module tb_uart_send;
    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BPS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    uart_send_if tx_if ();

    uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
        .clk (clk),
        .rst (rst),
        .tx  (tx_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] bits;   // transmitted 8N1 bits, index 0 = start bit
        logic       par;
        bit         noise;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame, sampling every cycle from the accept edge (t=0) to the done cycle.
    task automatic frame(input logic [7:0] d, input logic [9:0] bits, input logic par,
                         input bit noise, input bit chain, input logic [7:0] nd,
                         input bit pre_accepted);
        logic [10:0] seq;
        logic [10:0] mid;
        logic [10:0] unstable;
        int busy_n;
        int done_n;
        int done_t;
        int k;
        seq = '1;
        seq[8:0] = bits[8:0];
`ifdef UART_TX_PARITY_EN
        seq[9] = par;
`endif
        mid = '1;
        unstable = '0;
        busy_n = 0;
        done_n = 0;
        done_t = -1;
        if (!pre_accepted) begin
            tx_if.send_en = 1'b1;
            tx_if.send_data = d;
            cyc();
            tx_if.send_en = 1'b0;
            tx_if.send_data = 8'h00;
        end
        for (int t = 0; t <= FRAME; t++) begin
            if (t < FRAME) begin
                k = t / BPS;
                if (tx_if.uart_txd !== seq[k]) unstable[k] = 1'b1;
                if (t % BPS == BPS / 2) mid[k] = tx_if.uart_txd;
            end
            if (tx_if.uart_busy === 1'b1) busy_n++;
            if (tx_if.uart_done === 1'b1) begin
                done_n++;
                done_t = t;
            end
            if (noise) begin
                tx_if.send_en = (t == 20 || t == 50);
                tx_if.send_data = (t == 20 || t == 50) ? 8'hFF : d;
            end
            if (t == FRAME && chain) begin
                tx_if.send_en = 1'b1;
                tx_if.send_data = nd;
            end
            if (t < FRAME) cyc();
        end
        check("txd_seq", 32'(mid[NB-1:0]), 32'(seq[NB-1:0]));
        check("txd_bit_width", 32'(unstable), 32'd0);
        check("busy_cycles", busy_n, FRAME);
        check("done_count", done_n, 1);
        check("done_time", done_t, FRAME);
        check("txd_done_cycle", 32'(tx_if.uart_txd), 32'd1);
        $display("frame data=%02h mid=%03h seq=%03h busy=%0d done_t=%0d", d, mid[NB-1:0], seq[NB-1:0], busy_n, done_t);
        cyc();
        tx_if.send_en = 1'b0;
        if (!chain) check("done_one_cycle", 32'(tx_if.uart_done), 32'd0);
    endtask

    initial begin
        int err;
        tx_if.send_en = 1'b0;
        tx_if.send_data = 8'h00;

        vecs[0] = '{d: 8'h55, bits: 10'b1010101010, par: 1'b0, noise: 1'b0};
        vecs[1] = '{d: 8'hA3, bits: 10'b1101000110, par: 1'b0, noise: 1'b1};
        vecs[2] = '{d: 8'h07, bits: 10'b1000001110, par: 1'b1, noise: 1'b0};
        vecs[3] = '{d: 8'h03, bits: 10'b1000000110, par: 1'b0, noise: 1'b0};
        vecs[4] = '{d: 8'hFF, bits: 10'b1111111110, par: 1'b0, noise: 1'b0};
        vecs[5] = '{d: 8'h00, bits: 10'b1000000000, par: 1'b0, noise: 1'b0};

        // Reset values, then 100 idle cycles with no request.
        repeat (3) cyc();
        check("rst_txd", 32'(tx_if.uart_txd), 32'd1);
        check("rst_busy", 32'(tx_if.uart_busy), 32'd0);
        check("rst_done", 32'(tx_if.uart_done), 32'd0);
        rst = 1'b0;
        err = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (tx_if.uart_txd !== 1'b1 || tx_if.uart_busy !== 1'b0 || tx_if.uart_done !== 1'b0) err++;
        end
        check("idle_100", err, 0);
        $display("idle 100 cycles errors=%0d", err);

        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].d, vecs[i].bits, vecs[i].par, vecs[i].noise, 1'b0, 8'h00, 1'b0);
            repeat (3) cyc();
        end

        // Back-to-back: second request lands in the done cycle.
        frame(8'h01, 10'b1000000010, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        frame(8'h80, 10'b1100000000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc();

        // Reset mid-frame.
        tx_if.send_en = 1'b1;
        tx_if.send_data = 8'h00;
        cyc();
        tx_if.send_en = 1'b0;
        repeat (45) cyc();
        check("pre_rst_busy", 32'(tx_if.uart_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_txd", 32'(tx_if.uart_txd), 32'd1);
        check("midrst_busy", 32'(tx_if.uart_busy), 32'd0);
        check("midrst_done", 32'(tx_if.uart_done), 32'd0);
        err = 0;
        repeat (3) begin
            cyc();
            if (tx_if.uart_done !== 1'b0 || tx_if.uart_txd !== 1'b1) err++;
        end
        rst = 1'b0;
        repeat (120) begin
            cyc();
            if (tx_if.uart_done !== 1'b0 || tx_if.uart_txd !== 1'b1 || tx_if.uart_busy !== 1'b0) err++;
        end
        check("after_rst_quiet", err, 0);
        $display("reset mid-frame quiet errors=%0d", err);
        frame(8'h00, 10'b1000000000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_send.md
# uart_send

UART transmitter for the FPGA_RS232 design. It is the transmit-side counterpart of the serial receiver. It accepts one byte per request from on-chip logic and shifts it out on the serial TX pin as an 8N1 frame (optionally 8E1): start bit, 8 data bits LSB first, optional even parity, one stop bit. It reports busy status and end of frame so a loopback or echo controller can pace requests.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 9600, baud rate; bit period BPS_CNT = CLK_FREQ/UART_BPS clocks (integer division, 5208 at defaults)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- send_en  input  1  single-cycle transmit request
- send_data  input  8  byte to transmit, sampled when a request is accepted
- uart_txd  output  1  serial output, idle high
- uart_busy  output  1  high from the cycle after acceptance until the end of the stop bit
- uart_done  output  1  one-cycle pulse when the stop bit completes

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: uart_txd=1, uart_busy=0. A request is accepted on a rising edge where send_en=1 and uart_busy=0. On that edge send_data is latched into the shift register, the state goes to START, uart_txd goes 0, and uart_busy goes 1.
- Bit timer clk_cnt (16 bit) counts 0..BPS_CNT-1 in every non-IDLE state. It wraps to 0 at BPS_CNT-1, and that edge advances the bit.
- START -> DATA after one bit period.
- DATA: bit_cnt (4 bit) runs 0..7 and uart_txd = data[bit_cnt], LSB first. After bit 7 the block goes to PARITY or STOP.
- PARITY: uart_txd = XOR of the 8 latched bits (even parity). It lasts one bit period, then the block goes to STOP.
- STOP: uart_txd=1 for one bit period. On the final edge the block returns to IDLE, uart_busy goes 0, and uart_done goes 1 for exactly one cycle.
- Requests while uart_busy=1 are ignored and not queued. Changes to send_data while busy have no effect.
- A request in the cycle where uart_done=1 is accepted, giving back-to-back frames with no idle gap.
- All outputs are registered and glitch-free on uart_txd.
- Elaboration must fail if BPS_CNT < 2 or BPS_CNT > 65535.

## Timing
- Reset values: uart_txd=1, uart_busy=0, uart_done=0, state=IDLE, clk_cnt=0, bit_cnt=0, shift register=0.
- Reset asserted mid-frame: uart_txd returns high immediately (asynchronous) and the frame is abandoned. No uart_done is produced.
- Latency from the request edge to the uart_txd falling edge is 1 clock, registered at the accept edge.
- Frame length is exactly 10*BPS_CNT clocks (11*BPS_CNT with parity) from the uart_txd fall to the uart_done edge.
- uart_busy is high for exactly the frame length. uart_done coincides with the first cycle of uart_busy=0.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and frames are 8E1, 11 bit periods.
- UART_TX_PARITY_EN undefined: the PARITY state and parity logic are absent, and frames are 8N1, 10 bit periods.

## Structure
- Shared package uart_pkg holds:
  - the tx state encoding constants
  - the BPS_CNT computation function, shared with the receiver
  - DATA_BITS=8
- Sub-module uart_bps_tick: bit-period counter with enable. It outputs a one-cycle tick at count BPS_CNT-1 and clears when disabled. It is reusable by the receiver.

## Test plan
Benches use CLK_FREQ=1000000 and UART_BPS=100000, so BPS_CNT=10.
- Reset release, no request -> uart_txd=1, uart_busy=0, uart_done=0 held for 100 cycles.
- send_en pulse with 0x55, no parity -> uart_txd bit sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 10 clocks. uart_done pulses once at clock 100 after the accept edge. uart_busy is high for 100 cycles.
- Request 0xA3 accepted, then send_en pulses with 0xFF at cycles 20 and 50 -> those pulses are ignored and the frame carries 0xA3 (bits 1,1,0,0,0,1,0,1).
- Request 0x01, then request 0x80 asserted in the uart_done cycle -> the second start bit begins in the next cycle with no idle high gap. Received bytes are 0x01 then 0x80.
- rst asserted at cycle 45 of a 0x00 frame -> uart_txd=1 in the same cycle, uart_busy=0, and no uart_done. A new request after rst deasserts produces a full, correct frame.
- UART_TX_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bits 1 and 0 respectively. Frame length is 110 clocks.
